// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled mid-bit from a synchronized serial line,
// delivered through a one-entry valid/ready holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       rx_ready_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_s;
  logic             good_byte;

  // Stage 0: two-flop synchronizer on the asynchronous line
  assign sync1_d = data_i;
  assign sync2_d = sync1_q;
  assign rx_s    = sync2_q;

  // Stage 1: frame FSM, sampling at the middle of each bit period
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good_byte   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Return to IDLE mid-stop-bit so a back-to-back start edge is caught
            good_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage 2: holding register; a handshake in the same cycle frees the slot
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (good_byte) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign rx_ready_o  = ~valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a waveform-level frame decoder predicts the
// bytes and error pulses; a negedge monitor checks what the DUT delivers.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       rx_ready_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .rx_ready_o (rx_ready_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  bit         line_q[$];
  bit         rst_q[$];
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  int         ferr_seen = 0;
  int         ovr_seen = 0;
  bit         held = 1'b0;
  bit         model_rdy = 1'b1;
  int         cyc = 0;
  int         first_low_cyc = -1;
  int         valid_rise_cyc = -1;
  logic       valid_prev = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // ---------------- stimulus construction (one entry per clock) ----------------
  task automatic add_level(input bit lvl, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      line_q.push_back(lvl);
      rst_q.push_back(1'b0);
    end
  endtask

  // stop_low_bits = 0 gives a good stop bit; otherwise the stop bit is held low that many bits
  task automatic add_frame(input logic [7:0] b, input int stop_low_bits);
    add_level(1'b0, CPB);
    for (int k = 0; k < 8; k++) add_level(b[k], CPB);
    if (stop_low_bits > 0) add_level(1'b0, stop_low_bits * CPB);
    add_level(1'b1, CPB);
  endtask

  // ---------------- reference model ----------------
  function automatic bit w(input int idx);
    return (idx < line_q.size()) ? line_q[idx] : 1'b1;
  endfunction

  task automatic deliver(input logic [7:0] b);
    if (model_rdy) exp_q.push_back(b);
    else if (!held) begin
      exp_q.push_back(b);
      held = 1'b1;
    end else exp_ovr++;
  endtask

  // Decode the line between entries lo..hi: start edge, mid-start check,
  // 8 mid-bit samples LSB first, then the stop sample one bit later.
  task automatic decode(input int lo, input int hi);
    int i;
    int mid;
    int stp;
    logic [7:0] b;
    i = lo;
    while (i <= hi) begin
      if (w(i)) begin
        i++;
        continue;
      end
      mid = i + HALF;
      if (mid > hi) break;
      if (w(mid)) begin
        i = mid + 1;
        continue;
      end
      stp = mid + 9 * CPB;
      if (stp > hi) break;
      for (int k = 0; k < 8; k++) b[k] = w(mid + (k + 1) * CPB);
      if (w(stp)) begin
        deliver(b);
        i = stp + 1;
      end else begin
        exp_ferr++;
        i = stp + 1;
        while (i <= hi && !w(i)) i++;
        i++;
      end
    end
  endtask

  // A reset entry cuts off everything the receiver would still have to
  // decide (line entries from r-2 on); the line is watched again from r+1.
  task automatic model_phase();
    int lo;
    lo = 0;
    for (int r = 0; r < rst_q.size(); r++) begin
      if (rst_q[r]) begin
        decode(lo, r - 3);
        lo = r + 1;
      end
    end
    decode(lo, line_q.size() - 1);
  endtask

  task automatic run_phase(input string name, input bit rdy);
    model_rdy = rdy;
    ready_i   = rdy;
    model_phase();
    first_low_cyc  = -1;
    valid_rise_cyc = -1;
    for (int k = 0; k < line_q.size(); k++) begin
      @(posedge clk);
      #1;
      data_i = line_q[k];
      rst    = rst_q[k];
      if (!line_q[k] && first_low_cyc < 0) first_low_cyc = cyc;
    end
    @(posedge clk);
    #1;
    data_i = 1'b1;
    rst    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({name, " frame_err pulses"}, ferr_seen, exp_ferr);
    check({name, " overrun pulses"}, ovr_seen, exp_ovr);
    if (rdy) check({name, " bytes outstanding"}, exp_q.size(), 0);
    line_q.delete();
    rst_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (valid_o && ready_i) begin
        check("byte expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data_o", data_o, exp_q.pop_front());
      end
      if (frame_err_o) ferr_seen++;
      if (overrun_o) ovr_seen++;
      if (valid_o && !valid_prev && valid_rise_cyc < 0) valid_rise_cyc = cyc;
    end
    valid_prev = valid_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s;
    logic [7:0] rb;
    rst = 1'b1;
    data_i = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid_o", valid_o, 0);
    check("reset data_o", data_o, 0);
    check("reset rx_ready_o", rx_ready_o, 1);
    check("reset frame_err_o", frame_err_o, 0);
    check("reset overrun_o", overrun_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single byte plus latency
    add_level(1'b1, 2 * CPB);
    add_frame(8'h55, 0);
    add_level(1'b1, 3 * CPB);
    run_phase("single 55", 1'b1);
    lat = valid_rise_cyc - first_low_cyc - 1;
    check("latency in 154..156", (lat >= 154 && lat <= 156) ? 155 : lat, 155);

    // back-to-back frames
    add_level(1'b1, CPB);
    add_frame(8'hA3, 0);
    add_frame(8'h0F, 0);
    add_level(1'b1, 3 * CPB);
    run_phase("b2b A3 0F", 1'b1);

    // start-bit glitch, then a normal frame to show the FSM is idle again
    add_level(1'b1, CPB);
    add_level(1'b0, 6);
    add_level(1'b1, 4 * CPB);
    check("glitch model bytes", exp_q.size(), 0);
    add_frame(8'h5A, 0);
    add_level(1'b1, 3 * CPB);
    run_phase("glitch", 1'b1);

    // break: stop bit held low for 20 bit times
    add_level(1'b1, CPB);
    add_frame(8'hFF, 20);
    add_level(1'b1, 3 * CPB);
    run_phase("break", 1'b1);
    check("break frame_err total", ferr_seen, 1);

    // overrun with consumer stalled
    held = 1'b0;
    add_level(1'b1, CPB);
    add_frame(8'h12, 0);
    add_level(1'b1, 2 * CPB);
    add_frame(8'h34, 0);
    add_level(1'b1, 3 * CPB);
    run_phase("overrun", 1'b0);
    check("stalled valid_o", valid_o, 1);
    check("stalled data_o", data_o, 8'h12);
    check("stalled rx_ready_o", rx_ready_o, 0);
    check("overrun total", ovr_seen, 1);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    held = 1'b0;
    check("after handshake valid_o", valid_o, 0);
    check("after handshake rx_ready_o", rx_ready_o, 1);
    check("after handshake data_o held", data_o, 8'h12);
    check("after handshake outstanding", exp_q.size(), 0);

    // reset during data bit 4 of C6; the line is still low afterwards, so a
    // fresh start edge is seen there and decoded like any other frame
    add_level(1'b1, CPB);
    s = line_q.size();
    add_frame(8'hC6, 0);
    rst_q[s + 5 * CPB + 4] = 1'b1;
    add_level(1'b1, 6 * CPB);
    add_frame(8'h3C, 0);
    add_level(1'b1, 3 * CPB);
    run_phase("reset mid-frame", 1'b1);

    // randomized mix of good frames, bad stop bits, glitches and gaps
    add_level(1'b1, CPB);
    for (int n = 0; n < 14; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rb  = 8'($urandom_range(0, 255));
      if (sel < 2) begin
        add_level(1'b0, $urandom_range(1, 6));
        add_level(1'b1, CPB);
      end else if (sel < 4) begin
        add_frame(rb, $urandom_range(1, 3));
      end else begin
        add_frame(rb, 0);
      end
      add_level(1'b1, $urandom_range(0, 2) * CPB + $urandom_range(0, 5));
    end
    add_level(1'b1, 3 * CPB);
    run_phase("random", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
